// File: rtl/ifetch_line_buffer_pkg.sv
// Shared types for the instruction-side line buffer: FSM states, line geometry
// and the word-select helper.
package ifetch_line_buffer_pkg;

  localparam int LINE_BITS   = 256;
  localparam int OFFSET_BITS = 5;
  localparam int TAG_BITS    = 27;
  localparam int WORD_BITS   = 32;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FETCH = 1'b1
  } state_t;

  function automatic logic [WORD_BITS-1:0] line_word(
    input logic [LINE_BITS-1:0] line,
    input logic [2:0]           idx
  );
    return line[{idx, 5'd0} +: WORD_BITS];
  endfunction

endpackage

// File: rtl/ifetch_line_buffer_line_register.sv
// Storage for the single cached line: data, tag and valid bit.
// clear has priority over load so a reset during a fill leaves the buffer empty.
module ifetch_line_buffer_line_register
  import ifetch_line_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 clear,
  input  logic                 load,
  input  logic [LINE_BITS-1:0] line_in,
  input  logic [TAG_BITS-1:0]  tag_in,
  output logic [LINE_BITS-1:0] line,
  output logic [TAG_BITS-1:0]  tag,
  output logic                 valid
);

  always_ff @(posedge clk) begin
    if (clear) begin
      line  <= '0;
      tag   <= '0;
      valid <= 1'b0;
    end else if (load) begin
      line  <= line_in;
      tag   <= tag_in;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction buffer: zero-latency hits, line-aligned refill on miss.
// The refill address comes from the captured miss tag so it stays stable while the PC moves.
module ifetch_line_buffer
  import ifetch_line_buffer_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          imem_address_i,
  input  logic                 imem_read_i,
  output logic [31:0]          imem_rdata_o,
  output logic                 imem_resp_o,
  output logic [31:0]          pmem_address_o,
  output logic                 pmem_read_o,
  input  logic [LINE_BITS-1:0] pmem_rdata_i,
  input  logic                 pmem_resp_i
);

  state_t              state;
  logic [TAG_BITS-1:0] miss_tag;

  logic [LINE_BITS-1:0] line;
  logic [TAG_BITS-1:0]  line_tag;
  logic                 line_valid;

  logic [TAG_BITS-1:0] req_tag;
  logic [2:0]          req_word;
  logic                hit;
  logic                fill;
  logic                unused_byte_bits;

  assign req_tag          = imem_address_i[31:OFFSET_BITS];
  assign req_word         = imem_address_i[4:2];
  assign unused_byte_bits = ^imem_address_i[1:0];

  assign hit  = (state == S_IDLE) && imem_read_i && line_valid && (line_tag == req_tag);
  assign fill = (state == S_FETCH) && pmem_resp_i && !rst;

  ifetch_line_buffer_line_register u_line (
    .clk     (clk),
    .clear   (rst),
    .load    (fill),
    .line_in (pmem_rdata_i),
    .tag_in  (miss_tag),
    .line    (line),
    .tag     (line_tag),
    .valid   (line_valid)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      miss_tag <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (imem_read_i && !hit) begin
            miss_tag <= req_tag;
            state    <= S_FETCH;
          end
        end
        S_FETCH: begin
          // The fill is never abandoned, even if the fetch port moves away.
          if (pmem_resp_i) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    imem_resp_o    = hit;
    imem_rdata_o   = hit ? line_word(line, req_word) : 32'd0;
    pmem_read_o    = (state == S_FETCH);
    pmem_address_o = (state == S_FETCH) ? {miss_tag, {OFFSET_BITS{1'b0}}} : 32'd0;
  end

endmodule

// File: tb/tb_ifetch_line_buffer.sv
// Directed bench for ifetch_line_buffer: inputs change 1ns after the rising edge,
// outputs are checked mid-cycle.
module tb_ifetch_line_buffer;

  logic         clk = 1'b0;
  logic         rst;
  logic [31:0]  imem_address_i;
  logic         imem_read_i;
  logic [31:0]  imem_rdata_o;
  logic         imem_resp_o;
  logic [31:0]  pmem_address_o;
  logic         pmem_read_o;
  logic [255:0] pmem_rdata_i;
  logic         pmem_resp_i;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ifetch_line_buffer dut (
    .clk            (clk),
    .rst            (rst),
    .imem_address_i (imem_address_i),
    .imem_read_i    (imem_read_i),
    .imem_rdata_o   (imem_rdata_o),
    .imem_resp_o    (imem_resp_o),
    .pmem_address_o (pmem_address_o),
    .pmem_read_o    (pmem_read_o),
    .pmem_rdata_i   (pmem_rdata_i),
    .pmem_resp_i    (pmem_resp_i)
  );

  function automatic logic [255:0] mkline(input logic [31:0] base);
    logic [255:0] l;
    for (int k = 0; k < 8; k++) l[32*k +: 32] = base + k;
    return l;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic mid;
    #4;
  endtask

  // Checks a cycle where the buffer answers a hit.
  task automatic chk_hit(input string tag, input logic [31:0] data);
    chk({tag, "_resp"}, {31'd0, imem_resp_o}, 32'd1);
    chk({tag, "_rdata"}, imem_rdata_o, data);
    chk({tag, "_pread"}, {31'd0, pmem_read_o}, 32'd0);
  endtask

  // Checks a cycle spent waiting on memory for the given line address.
  task automatic chk_fetch(input string tag, input logic [31:0] addr);
    chk({tag, "_pread"}, {31'd0, pmem_read_o}, 32'd1);
    chk({tag, "_paddr"}, pmem_address_o, addr);
    chk({tag, "_resp"}, {31'd0, imem_resp_o}, 32'd0);
    chk({tag, "_rdata"}, imem_rdata_o, 32'd0);
  endtask

  initial begin
    rst            = 1'b1;
    imem_address_i = 32'd0;
    imem_read_i    = 1'b0;
    pmem_rdata_i   = '0;
    pmem_resp_i    = 1'b0;
    tick(); tick();
    rst = 1'b0;
    mid();
    chk("reset_resp",  {31'd0, imem_resp_o}, 32'd0);
    chk("reset_rdata", imem_rdata_o, 32'd0);
    chk("reset_pread", {31'd0, pmem_read_o}, 32'd0);
    chk("reset_paddr", pmem_address_o, 32'd0);

    // Cold miss on 0x60, memory answers in the third fetch cycle.
    tick();
    imem_address_i = 32'h0000_0060;
    imem_read_i    = 1'b1;
    mid();
    chk("cold_c0_resp",  {31'd0, imem_resp_o}, 32'd0);
    chk("cold_c0_pread", {31'd0, pmem_read_o}, 32'd0);
    tick(); mid();
    chk_fetch("cold_c1", 32'h0000_0060);
    tick(); mid();
    chk_fetch("cold_c2", 32'h0000_0060);
    tick();
    pmem_rdata_i = mkline(32'hA000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("cold_c3", 32'h0000_0060);
    tick();
    pmem_resp_i  = 1'b0;
    pmem_rdata_i = '0;
    mid();
    chk_hit("cold_c4", 32'hA000_0000);

    // Streaming hits across the rest of the line.
    for (int k = 1; k < 8; k++) begin
      tick();
      imem_address_i = 32'h0000_0060 + 32'(4 * k);
      mid();
      chk_hit($sformatf("stream_w%0d", k), 32'hA000_0000 + 32'(k));
    end

    // Byte-offset bits are ignored.
    tick();
    imem_address_i = 32'h0000_0063;
    mid();
    chk_hit("lowbits", 32'hA000_0000);

    // Crossing into the next line misses and replaces the buffer.
    tick();
    imem_address_i = 32'h0000_0080;
    mid();
    chk("cross_miss_resp", {31'd0, imem_resp_o}, 32'd0);
    tick();
    pmem_rdata_i = mkline(32'hB000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("cross_fetch", 32'h0000_0080);
    tick();
    pmem_resp_i = 1'b0;
    imem_address_i = 32'h0000_0088;
    mid();
    chk_hit("cross_hit", 32'hB000_0002);
    tick();
    imem_address_i = 32'h0000_0060;
    mid();
    chk("cross_old_resp", {31'd0, imem_resp_o}, 32'd0);
    tick();
    pmem_rdata_i = mkline(32'hA000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("cross_refetch", 32'h0000_0060);
    tick();
    pmem_resp_i = 1'b0;

    // Address moves away while the fill of 0x100 is in flight.
    imem_address_i = 32'h0000_0100;
    mid();
    chk("mid_miss_resp", {31'd0, imem_resp_o}, 32'd0);
    tick();
    imem_address_i = 32'h0000_0004;
    mid();
    chk_fetch("mid_f1", 32'h0000_0100);
    tick();
    pmem_rdata_i = mkline(32'hC000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("mid_f2", 32'h0000_0100);
    tick();
    pmem_resp_i = 1'b0;
    mid();
    chk("mid_new_miss_resp",  {31'd0, imem_resp_o}, 32'd0);
    chk("mid_new_miss_pread", {31'd0, pmem_read_o}, 32'd0);
    tick();
    pmem_rdata_i = mkline(32'hD000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("mid_f3", 32'h0000_0000);
    tick();
    pmem_resp_i = 1'b0;
    mid();
    chk_hit("mid_hit", 32'hD000_0001);

    // Read drops during a fill: the fill still completes.
    tick();
    imem_address_i = 32'h0000_0300;
    mid();
    chk("drop_miss_resp", {31'd0, imem_resp_o}, 32'd0);
    tick();
    imem_read_i = 1'b0;
    mid();
    chk_fetch("drop_f1", 32'h0000_0300);
    tick();
    pmem_rdata_i = mkline(32'hF000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("drop_f2", 32'h0000_0300);
    tick();
    pmem_resp_i = 1'b0;
    mid();
    chk("drop_idle_resp",  {31'd0, imem_resp_o}, 32'd0);
    chk("drop_idle_pread", {31'd0, pmem_read_o}, 32'd0);
    tick();
    imem_read_i    = 1'b1;
    imem_address_i = 32'h0000_0304;
    mid();
    chk_hit("drop_hit", 32'hF000_0001);

    // Reset during a fill of 0x200, followed by a late memory response.
    tick();
    imem_address_i = 32'h0000_0200;
    tick(); mid();
    chk_fetch("rst_f1", 32'h0000_0200);
    tick();
    rst         = 1'b1;
    imem_read_i = 1'b0;
    tick();
    rst = 1'b0;
    mid();
    chk("rst_pread", {31'd0, pmem_read_o}, 32'd0);
    chk("rst_paddr", pmem_address_o, 32'd0);
    tick();
    pmem_rdata_i = mkline(32'hE000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk("rst_late_pread", {31'd0, pmem_read_o}, 32'd0);
    tick();
    pmem_resp_i = 1'b0;
    // The previously held line (0x300) must be gone after reset.
    imem_read_i    = 1'b1;
    imem_address_i = 32'h0000_0304;
    mid();
    chk("rst_cleared_resp", {31'd0, imem_resp_o}, 32'd0);
    tick();
    pmem_rdata_i = mkline(32'hF000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("rst_refill", 32'h0000_0300);
    tick();
    pmem_resp_i    = 1'b0;
    imem_address_i = 32'h0000_0200;
    mid();
    chk("rst_late_ignored_resp", {31'd0, imem_resp_o}, 32'd0);
    tick();
    pmem_rdata_i = mkline(32'hE000_0000);
    pmem_resp_i  = 1'b1;
    mid();
    chk_fetch("rst_same_addr", 32'h0000_0200);
    tick();
    pmem_resp_i = 1'b0;
    mid();
    chk_hit("rst_final_hit", 32'hE000_0000);

    tick();
    imem_read_i = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ifetch_line_buffer.md
# ifetch_line_buffer

Instruction-side memory responder for the fetch stage. Serves 32-bit instruction reads from the PC-driven fetch port out of a single 256-bit line buffer. On a miss it issues a line-aligned read to physical memory, captures the returned line and then serves the request. It sits between the fetch stage's instruction-memory port and the instruction-side physical memory (or arbiter) port.

## Interface
Parameters:
- none (line size fixed at 256 bits / 8 words; address fixed at 32 bits)

Ports:
- Clocking and reset: one clock; reset is synchronous and active-high.
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- imem_address_i  in  32  fetch byte address (PC); bits [1:0] ignored
- imem_read_i  in  1  fetch request, level-held until imem_resp_o
- imem_rdata_o  out  32  instruction word; valid only when imem_resp_o=1
- imem_resp_o  out  1  request served this cycle
- pmem_address_o  out  32  line-aligned memory address ({tag,5'b0})
- pmem_read_o  out  1  line read request, held until pmem_resp_i
- pmem_rdata_i  in  256  returned line; word k at bits [32k+31:32k]
- pmem_resp_i  in  1  line valid this cycle

## Operation
- Address split: tag = addr[31:5], word offset = addr[4:2].
- State held: line[255:0], line_tag[26:0], line_valid, fsm state, captured miss tag.
- FSM states:
  - S_IDLE:
    - hit = imem_read_i & line_valid & (line_tag == addr[31:5]).
    - On hit: imem_resp_o=1 and imem_rdata_o=line word[offset], combinationally, same cycle. Remain in S_IDLE.
    - On miss with imem_read_i=1: capture addr[31:5] into miss tag, go to S_FETCH.
    - With imem_read_i=0: outputs idle.
  - S_FETCH:
    - pmem_read_o=1, pmem_address_o={miss tag,5'b0}, imem_resp_o=0.
    - On pmem_resp_i: line<=pmem_rdata_i, line_tag<=miss tag, line_valid<=1, go to S_IDLE.
- In S_FETCH, pmem_address_o is driven from the captured miss tag, not the live imem_address_i, so the memory address is stable for the whole transaction.
- Outputs that are not asserted are driven to 0: imem_rdata_o=0 when imem_resp_o=0; pmem_address_o=0 outside S_FETCH.

## Timing
- Reset values: state=S_IDLE, line_valid=0, line=0, line_tag=0; all outputs 0.
- Hit latency: 0 cycles (response in the request cycle).
- Miss latency:
  - Cycle 0: request arrives, miss detected.
  - Cycles 1..N: S_FETCH; N = memory latency, ≥1.
  - Cycle N+1: S_IDLE, hit, imem_resp_o=1.
- Fetch-port changes during S_FETCH:
  - If imem_read_i drops or imem_address_i changes, the fill still completes; the memory read is never abandoned.
  - The request is re-evaluated in S_IDLE: it may hit, or start a new miss.
- pmem_resp_i in S_IDLE is ignored: no state change.
- Reset asserted during S_FETCH:
  - Next cycle: S_IDLE, line_valid=0, pmem_read_o=0.
  - A late pmem_resp_i after reset is ignored.
- Back-to-back requests within one line: one response per cycle, no bubbles.
- Sequential fetch from word 7 into the next line: a miss.

## Structure
- Shared package (rv32i_types or a new icache_types):
  - state enum: S_IDLE, S_FETCH
  - localparams: LINE_BITS=256, OFFSET_BITS=5, TAG_BITS=27
- Sub-module line_register: holds line, tag and valid, with load/clear. Word select and FSM stay in the top module.

## Test plan
- Cold miss:
  - Stimulus: after reset, read 0x0000_0060; memory returns line with word k = 0xA000_0000+k after 3 cycles.
  - Response: pmem_address_o=0x0000_0060 held 3 cycles; imem_resp_o=1 with rdata=0xA000_0000 on cycle 4.
- Streaming hits:
  - Stimulus: addresses 0x64, 0x68 … 0x7C in consecutive cycles.
  - Response: imem_resp_o=1 every cycle; rdata 0xA000_0001..0xA000_0007; pmem_read_o stays 0.
- Line crossing:
  - Stimulus: read 0x80.
  - Response: miss; pmem_address_o=0x80; old line replaced after fill; subsequent 0x60 misses again.
- Address change mid-fill:
  - Stimulus: miss on 0x100; switch address to 0x04 during S_FETCH.
  - Response: pmem_address_o stays 0x100 until pmem_resp_i; then 0x04 issues a new miss.
- Reset mid-fill:
  - Stimulus: assert rst during S_FETCH, deassert, then assert pmem_resp_i one cycle later.
  - Response: pmem_read_o=0, line_valid=0; the late response is ignored; a read of the same address misses.
- Low-bit tolerance:
  - Stimulus: read 0x0000_0063 after line 0x60 is filled.
  - Response: hit returning word 0 (0xA000_0000).
